// File: rtl/register_bank_pkg.sv
// Shared types for the register bank: the UART packet carried on the
// response stream, its source tags and the serialiser state encoding.
package register_bank_pkg;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;

  localparam logic [7:0] SYNC_SOURCE = 8'h01;
  localparam logic [7:0] DATA_SOURCE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SEND_SYNC,
    SEND_ADDR,
    SEND_DATA
  } rbState_t;

endpackage

// File: rtl/register_bank.sv
// Bank of 32-bit registers written from the UART receive path; reads are
// answered as a framed packet stream (sync, address, four data bytes MSB first).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] ID_VALUE  = 32'h0000_0001,
  parameter logic [7:0]  SYNC_DATA = 8'hA5
) (
  input  logic                  ipClk,
  input  logic                  reset,
  input  logic                  ipWrEnable,
  input  logic [7:0]            ipAddress,
  input  logic [31:0]           ipWrData,
  input  logic                  ipRdEnable,
  output logic                  opRdBusy,
  output UART_PACKET            opTxStream,
  input  logic                  ipTxReady,
  output logic [NUM_REGS*32-1:0] opRegisters
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic [31:0]      regBank [NUM_REGS];
  logic [IDX_W-1:0] addrIdx;
  logic             addrInRange;
  logic             addrIsZero;
  logic [31:0]      rdValue;

  rbState_t    state;
  logic [1:0]  byteCnt;
  logic [7:0]  capAddr;
  logic [31:0] snapshot;
  logic        handshake;

  function automatic logic [7:0] selByte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd3:    b = word[31:24];
      2'd2:    b = word[23:16];
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  assign addrIdx     = ipAddress[IDX_W-1:0];
  assign addrInRange = ({1'b0, ipAddress} < NUM_REGS_W);
  assign addrIsZero  = (ipAddress == 8'h00);
  assign handshake   = opTxStream.Valid && ipTxReady;

  // Value seen by a read this cycle: always the pre-write contents.
  always_comb begin
    rdValue = 32'h0000_0000;
    if (addrIsZero)
      rdValue = ID_VALUE;
    else if (addrInRange)
      rdValue = regBank[addrIdx];
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++)
        regBank[k] <= 32'h0000_0000;
    end else if (ipWrEnable && addrInRange && !addrIsZero) begin
      regBank[addrIdx] <= ipWrData;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : gExport
    if (k == 0) begin : gId
      assign opRegisters[31:0] = ID_VALUE;
    end else begin : gReg
      assign opRegisters[32*k +: 32] = regBank[k];
    end
  end

  // Response serialiser; outputs only change on an accepted read or a handshake.
  always_ff @(posedge ipClk) begin
    if (reset) begin
      state             <= IDLE;
      byteCnt           <= 2'd0;
      capAddr           <= 8'h00;
      snapshot          <= 32'h0000_0000;
      opRdBusy          <= 1'b0;
      opTxStream.Valid  <= 1'b0;
      opTxStream.Source <= 8'h00;
      opTxStream.Data   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (ipRdEnable) begin
            state             <= SEND_SYNC;
            capAddr           <= ipAddress;
            snapshot          <= rdValue;
            opRdBusy          <= 1'b1;
            opTxStream.Valid  <= 1'b1;
            opTxStream.Source <= SYNC_SOURCE;
            opTxStream.Data   <= SYNC_DATA;
          end
        end
        SEND_SYNC: begin
          if (handshake) begin
            state             <= SEND_ADDR;
            opTxStream.Source <= DATA_SOURCE;
            opTxStream.Data   <= capAddr;
          end
        end
        SEND_ADDR: begin
          if (handshake) begin
            state           <= SEND_DATA;
            byteCnt         <= 2'd3;
            opTxStream.Data <= selByte(snapshot, 2'd3);
          end
        end
        SEND_DATA: begin
          if (handshake) begin
            if (byteCnt == 2'd0) begin
              state             <= IDLE;
              opRdBusy          <= 1'b0;
              opTxStream.Valid  <= 1'b0;
              opTxStream.Source <= 8'h00;
              opTxStream.Data   <= 8'h00;
            end else begin
              byteCnt         <= byteCnt - 2'd1;
              opTxStream.Data <= selByte(snapshot, byteCnt - 2'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
